// File: rtl/bnn_pkg.sv
// bnn_pkg: shared definitions for the binary CNN sequencing controller.
// Contents: FSM state encoding, geometry helper functions, and default result widths.
package bnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONV1  = 3'd1,
    S_CONV2  = 3'd2,
    S_ARGMAX = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int ACC_W_DEF = 5;
  localparam int FC_W_DEF  = 10;

  // Number of valid conv output positions per channel (no padding, stride 1).
  function automatic int fmap_n(input int img_w, input int k);
    return (img_w - k + 1) * (img_w - k + 1);
  endfunction

  // Total weight words streamed across all channels in one phase.
  function automatic int wt_n(input int n_ch, input int k);
    return n_ch * k * k;
  endfunction

endpackage

// File: rtl/bnn_seq_ctrl_if.sv
// bnn_seq_ctrl_if: bundle of every non-clock/reset signal of bnn_seq_ctrl.
//   slave  : the controller side (takes start/conv/fc inputs, drives status/conv/class outputs)
//   master : the surrounding system (top-level handshake, conv units, fc array)
interface bnn_seq_ctrl_if
  import bnn_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_CLASS = 10,
  parameter int FC_W    = FC_W_DEF
);
  localparam int SUM_W = ACC_W + $clog2(N_CH) + 1;
  localparam int IDX_W = $clog2(N_CLASS);

  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    pic_din;
  logic [N_CH-1:0]         conv_done;
  logic [N_CH*ACC_W-1:0]   conv_result;
  logic [N_CH-1:0]         conv_result_valid;
  logic [N_CH-1:0]         conv_din;
  logic [N_CH-1:0]         conv_start;
  logic [N_CH-1:0]         weight_en;
  logic                    stage;
  logic [SUM_W-1:0]        conv2_sum;
  logic                    maxpool_valid;
  logic [N_CLASS*FC_W-1:0] fc_result;
  logic                    fc_result_valid;
  logic [N_CLASS-1:0]      classes;
  logic [IDX_W-1:0]        class_idx;

  modport slave (
    input  start, pic_din, conv_done, conv_result, conv_result_valid,
           fc_result, fc_result_valid,
    output busy, done, conv_din, conv_start, weight_en, stage,
           conv2_sum, maxpool_valid, classes, class_idx
  );

  modport master (
    output start, pic_din, conv_done, conv_result, conv_result_valid,
           fc_result, fc_result_valid,
    input  busy, done, conv_din, conv_start, weight_en, stage,
           conv2_sum, maxpool_valid, classes, class_idx
  );

endinterface

// File: rtl/bnn_argmax.sv
// bnn_argmax: snapshots the FC score vector and scans it one class per cycle.
//   i_start     : one-cycle pulse, captures i_scores and begins the scan
//   i_scores    : signed scores, class i at [i*FC_W +: FC_W]
//   o_finish    : high during the final compare cycle
//   o_classes   : one-hot winner, o_class_idx : winner index (both hold after the scan)
module bnn_argmax
  import bnn_pkg::*;
#(
  parameter int N_CLASS = 10,
  parameter int FC_W    = FC_W_DEF,
  localparam int IDX_W  = $clog2(N_CLASS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_start,
  input  logic [N_CLASS*FC_W-1:0] i_scores,
  output logic                    o_finish,
  output logic [N_CLASS-1:0]      o_classes,
  output logic [IDX_W-1:0]        o_class_idx
);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLASS - 1);
  localparam logic [FC_W-1:0]  FC_MIN   = {1'b1, {(FC_W-1){1'b0}}};

  logic [N_CLASS*FC_W-1:0] r_snap;
  logic                    r_run;
  logic [IDX_W-1:0]        r_idx;
  logic signed [FC_W-1:0]  r_best;
  logic signed [FC_W-1:0]  w_cand;
  logic                    w_win;
  logic [N_CLASS-1:0]      r_classes;
  logic [IDX_W-1:0]        r_class_idx;

  assign w_cand   = r_snap[r_idx*FC_W +: FC_W];
  // Class 0 always claims the first slot so a valid one-hot exists even when
  // every score sits at the minimum; later classes need a strictly larger score.
  assign w_win    = r_run && ((r_idx == '0) || (w_cand > r_best));
  assign o_finish = r_run && (r_idx == IDX_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_snap      <= '0;
      r_run       <= 1'b0;
      r_idx       <= '0;
      r_best      <= FC_MIN;
      r_classes   <= '0;
      r_class_idx <= '0;
    end else if (i_start) begin
      r_snap <= i_scores;
      r_run  <= 1'b1;
      r_idx  <= '0;
      r_best <= FC_MIN;
    end else if (r_run) begin
      if (w_win) begin
        r_best      <= w_cand;
        r_classes   <= {{(N_CLASS-1){1'b0}}, 1'b1} << r_idx;
        r_class_idx <= r_idx;
      end
      if (r_idx == IDX_LAST) r_run <= 1'b0;
      else                   r_idx <= r_idx + 1'b1;
    end
  end

  assign o_classes   = r_classes;
  assign o_class_idx = r_class_idx;

endmodule

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: sequences the binary CNN through CONV1, CONV2 replay, FC and argmax.
//   clk, rstn : rising-edge clock, asynchronous active-low reset
//   bus       : bnn_seq_ctrl_if.slave -- start/busy/done handshake, per-channel conv
//               control and data, channel sum / maxpool strobe, FC scores and class outputs
// Owns one binarised feature map per channel: written from conv results in CONV1,
// replayed serially into the conv units in CONV2.
module bnn_seq_ctrl
  import bnn_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int IMG_W   = 28,
  parameter int K       = 3,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int N_CLASS = 10,
  parameter int FC_W    = FC_W_DEF
) (
  input logic           clk,
  input logic           rstn,
  bnn_seq_ctrl_if.slave bus
);
  localparam int FMAP_N = fmap_n(IMG_W, K);
  localparam int WT_N   = wt_n(N_CH, K);
  localparam int KK     = K * K;
  localparam int PTR_W  = (FMAP_N > 1) ? $clog2(FMAP_N) : 1;
  localparam int WT_CW  = $clog2(WT_N + 1);
  localparam int SUM_W  = ACC_W + $clog2(N_CH) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FMAP_N - 1);
  localparam logic [WT_CW-1:0] WT_SAT   = WT_CW'(WT_N);

  state_t           r_state, w_state_next;
  logic             w_busy, w_done, w_stage, w_conv_phase, w_phase_entry;
  logic [N_CH-1:0]  r_done_seen, w_conv_start, w_weight_en, w_conv_din;
  logic [WT_CW-1:0] r_wt_cnt;
  logic [SUM_W-1:0] r_conv2_sum, w_sum;
  logic             r_maxpool_valid;
  logic             w_argmax_start, w_argmax_finish;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // stage reads 0 in IDLE as well as CONV1, so it is 0 out of reset.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_stage      = 1'b1;
    w_conv_phase = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_stage = 1'b0;
        if (bus.start) w_state_next = S_CONV1;
      end
      S_CONV1: begin
        w_stage      = 1'b0;
        w_conv_phase = 1'b1;
        if (&r_done_seen) w_state_next = S_CONV2;
      end
      S_CONV2: begin
        w_conv_phase = 1'b1;
        if (bus.fc_result_valid) w_state_next = S_ARGMAX;
      end
      S_ARGMAX: begin
        if (w_argmax_finish) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_stage      = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Per-phase bookkeeping (done_seen, weight counter, pointers) restarts on this.
  assign w_phase_entry = (w_state_next != r_state) &&
                         ((w_state_next == S_CONV1) || (w_state_next == S_CONV2));
  assign w_argmax_start = (r_state == S_CONV2) && bus.fc_result_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              r_done_seen <= '0;
    else if (w_phase_entry) r_done_seen <= '0;
    else                    r_done_seen <= r_done_seen | bus.conv_done;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       r_wt_cnt <= '0;
    else if (w_phase_entry)                          r_wt_cnt <= '0;
    else if ((|w_conv_start) && (r_wt_cnt != WT_SAT)) r_wt_cnt <= r_wt_cnt + 1'b1;
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    localparam logic [WT_CW-1:0] WT_LO = WT_CW'(gi * KK);
    localparam logic [WT_CW-1:0] WT_HI = WT_CW'((gi + 1) * KK);

    logic [FMAP_N-1:0] r_fmap;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic              w_sign;
    logic              w_wr;

    assign w_conv_start[gi] = w_conv_phase && !r_done_seen[gi];
    assign w_weight_en[gi]  = w_conv_start[gi] && (r_wt_cnt >= WT_LO) && (r_wt_cnt < WT_HI);

    assign w_sign    = bus.conv_result[gi*ACC_W + ACC_W - 1];
    assign w_wr      = (r_state == S_CONV1) && bus.conv_result_valid[gi];
    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_fmap <= '0;
        r_ptr  <= '0;
      end else begin
        // A non-negative result binarises to 1.
        if (w_wr) r_fmap[r_ptr] <= ~w_sign;
        if (w_phase_entry)
          r_ptr <= '0;
        else if (w_wr || ((r_state == S_CONV2) && w_conv_start[gi]))
          r_ptr <= w_ptr_inc;
      end
    end

    assign w_conv_din[gi] = (r_state == S_CONV1) ? bus.pic_din : r_fmap[r_ptr];
  end

  // Sign-extended lane sum; SUM_W leaves headroom for N_CH full-scale lanes.
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < N_CH; c++)
      w_sum = w_sum + SUM_W'($signed(bus.conv_result[c*ACC_W +: ACC_W]));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_conv2_sum     <= '0;
      r_maxpool_valid <= 1'b0;
    end else begin
      r_conv2_sum     <= w_sum;
      r_maxpool_valid <= (&bus.conv_result_valid) && (r_state == S_CONV2);
    end
  end

  bnn_argmax #(
    .N_CLASS (N_CLASS),
    .FC_W    (FC_W)
  ) u_argmax (
    .clk         (clk),
    .rstn        (rstn),
    .i_start     (w_argmax_start),
    .i_scores    (bus.fc_result),
    .o_finish    (w_argmax_finish),
    .o_classes   (bus.classes),
    .o_class_idx (bus.class_idx)
  );

  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.stage         = w_stage;
  assign bus.conv_start    = w_conv_start;
  assign bus.weight_en     = w_weight_en;
  assign bus.conv_din      = w_conv_din;
  assign bus.conv2_sum     = r_conv2_sum;
  assign bus.maxpool_valid = r_maxpool_valid;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb_bnn_seq_ctrl: directed self-checking bench for bnn_seq_ctrl.
// Main instance uses the default geometry; a second 4-channel, 5x5-image instance
// exercises the wider channel sum.
module tb_bnn_seq_ctrl;
  localparam int FMAP_N = 676;
  localparam logic [4:0] POS = 5'd3;
  localparam logic [4:0] NEG = 5'h1D;  // -3

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bnn_seq_ctrl_if #(.N_CH(2), .ACC_W(5), .N_CLASS(10), .FC_W(10)) bus ();
  bnn_seq_ctrl_if #(.N_CH(4), .ACC_W(5), .N_CLASS(4), .FC_W(10)) bus4 ();

  bnn_seq_ctrl #(.N_CH(2), .IMG_W(28), .K(3), .ACC_W(5), .N_CLASS(10), .FC_W(10)) u_dut (
    .clk(clk), .rstn(rstn), .bus(bus));
  bnn_seq_ctrl #(.N_CH(4), .IMG_W(5), .K(3), .ACC_W(5), .N_CLASS(4), .FC_W(10)) u_dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4));

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [30:0] outs();
    return {bus.busy, bus.done, bus.conv_start, bus.weight_en, bus.conv_din, bus.stage,
            bus.conv2_sum, bus.maxpool_valid, bus.classes, bus.class_idx};
  endfunction

  task automatic init_inputs();
    bus.start = 0; bus.pic_din = 0; bus.conv_done = '0; bus.conv_result = '0;
    bus.conv_result_valid = '0; bus.fc_result = '0; bus.fc_result_valid = 0;
    bus4.start = 0; bus4.pic_din = 0; bus4.conv_done = '0; bus4.conv_result = '0;
    bus4.conv_result_valid = '0; bus4.fc_result = '0; bus4.fc_result_valid = 0;
  endtask

  // IDLE -> CONV1 -> CONV2; returns at the first CONV2 cycle.
  task automatic run_to_conv2();
    bus.start = 1; step(); bus.start = 0;
    bus.conv_done = 2'b11; step(); bus.conv_done = 2'b00;
    step();
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    step(); step(); #1;
    checks++; if (outs() !== 31'd0) begin failures++;
      $display("FAIL reset_outputs got=%0h exp=0", outs()); end
    checks++; if (bus4.conv2_sum !== 8'd0 || bus4.busy !== 1'b0) begin failures++;
      $display("FAIL reset_dut4 got sum=%0h busy=%0b exp=0", bus4.conv2_sum, bus4.busy); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_conv1();
    logic [1:0] exp_we;
    logic neg0;
    bus.start = 1; #1;
    checks++; if (bus.busy !== 1'b0) begin failures++;
      $display("FAIL busy_before_start got=%0b exp=0", bus.busy); end
    step(); bus.start = 0; #1;
    checks++; if ({bus.busy, bus.stage, bus.conv_start} !== 4'b1011) begin failures++;
      $display("FAIL start_to_conv1 got=%0b exp=1011", {bus.busy, bus.stage, bus.conv_start}); end
    for (int k = 0; k < 20; k++) begin
      bus.pic_din = k[0];
      bus.start   = (k == 5);
      exp_we = (k < 9) ? 2'b01 : (k < 18) ? 2'b10 : 2'b00;
      #1;
      checks++; if (bus.weight_en !== exp_we) begin failures++;
        $display("FAIL conv1_weight_en k=%0d got=%0b exp=%0b", k, bus.weight_en, exp_we); end
      checks++; if (bus.conv_din !== {k[0], k[0]}) begin failures++;
        $display("FAIL conv1_pic_din k=%0d got=%0b exp=%0b", k, bus.conv_din, {k[0], k[0]}); end
      step();
    end
    bus.start = 0; bus.pic_din = 0;
    // 677 writes: the last one lands on index 0 after the pointer wraps.
    for (int k = 0; k <= FMAP_N; k++) begin
      neg0 = (k == FMAP_N) ? 1'b1 : k[0];
      bus.conv_result = {neg0 ? POS : NEG, neg0 ? NEG : POS};
      bus.conv_result_valid = 2'b11;
      step();
    end
    bus.conv_result = '0; bus.conv_result_valid = 2'b00;
    bus.conv_done = 2'b11; step(); bus.conv_done = 2'b00; #1;
    checks++; if ({bus.stage, bus.conv_start} !== 3'b000) begin failures++;
      $display("FAIL done_seen_full got=%0b exp=000", {bus.stage, bus.conv_start}); end
    step(); #1;
    checks++; if ({bus.stage, bus.conv_start} !== 3'b111) begin failures++;
      $display("FAIL enter_conv2 got=%0b exp=111", {bus.stage, bus.conv_start}); end
  endtask

  task automatic test_conv2_replay();
    int idx;
    logic [1:0] exp_din, exp_we;
    for (int i = 0; i <= FMAP_N; i++) begin
      idx = i % FMAP_N;
      exp_din = (idx == 0 || (idx % 2) == 1) ? 2'b10 : 2'b01;
      exp_we  = (i < 9) ? 2'b01 : (i < 18) ? 2'b10 : 2'b00;
      #1;
      checks++; if (bus.conv_din !== exp_din) begin failures++;
        $display("FAIL replay_din i=%0d got=%0b exp=%0b", i, bus.conv_din, exp_din); end
      if (i < 20) begin
        checks++; if (bus.weight_en !== exp_we) begin failures++;
          $display("FAIL conv2_weight_en i=%0d got=%0b exp=%0b", i, bus.weight_en, exp_we); end
      end
      step();
    end
  endtask

  task automatic test_sum2();
    int got;
    bus.conv_result = {NEG, 5'd7}; bus.conv_result_valid = 2'b11;
    step(); got = $signed(bus.conv2_sum);
    checks++; if (got !== 4 || bus.maxpool_valid !== 1'b1) begin failures++;
      $display("FAIL sum2_pos got sum=%0d mp=%0b exp sum=4 mp=1", got, bus.maxpool_valid); end
    bus.conv_result = {5'h10, 5'h10}; bus.conv_result_valid = 2'b01;
    step(); got = $signed(bus.conv2_sum);
    checks++; if (got !== -32 || bus.maxpool_valid !== 1'b0) begin failures++;
      $display("FAIL sum2_neg got sum=%0d mp=%0b exp sum=-32 mp=0", got, bus.maxpool_valid); end
    bus.conv_result = '0; bus.conv_result_valid = 2'b00;
    bus.conv_done = 2'b11; step(); bus.conv_done = 2'b00; #1;
    checks++; if ({bus.busy, bus.stage, bus.conv_start} !== 4'b1100) begin failures++;
      $display("FAIL conv2_hold got=%0b exp=1100", {bus.busy, bus.stage, bus.conv_start}); end
  endtask

  task automatic test_argmax_main();
    int s [10] = '{5, -3, 40, 40, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) bus.fc_result[i*10 +: 10] = 10'(s[i]);
    bus.fc_result_valid = 1; step(); bus.fc_result_valid = 0;
    for (int i = 0; i < 10; i++) bus.fc_result[i*10 +: 10] = 10'h1FF;
    for (int j = 1; j <= 10; j++) begin
      #1;
      checks++; if ({bus.busy, bus.done} !== 2'b10) begin failures++;
        $display("FAIL argmax_busy j=%0d got=%0b exp=10", j, {bus.busy, bus.done}); end
      step();
    end
    #1;
    checks++; if ({bus.done, bus.classes, bus.class_idx} !== {1'b1, 10'b0000000100, 4'd2}) begin
      failures++; $display("FAIL argmax_result got done=%0b cls=%b idx=%0d exp 1 0000000100 2",
                           bus.done, bus.classes, bus.class_idx); end
    step(); #1;
    checks++; if ({bus.busy, bus.done, bus.classes, bus.class_idx} !== {2'b00, 10'b0000000100, 4'd2}) begin
      failures++; $display("FAIL done_one_cycle got busy=%0b done=%0b cls=%b idx=%0d",
                           bus.busy, bus.done, bus.classes, bus.class_idx); end
  endtask

  task automatic test_all_min();
    bus.start = 1; step(); bus.start = 0; #1;
    checks++; if (bus.classes !== 10'b0000000100 || bus.class_idx !== 4'd2) begin failures++;
      $display("FAIL classes_hold_on_start got cls=%b idx=%0d exp 0000000100 2",
               bus.classes, bus.class_idx); end
    bus.conv_done = 2'b11; step(); bus.conv_done = 2'b00; step();
    for (int i = 0; i < 10; i++) bus.fc_result[i*10 +: 10] = 10'h200;
    bus.fc_result_valid = 1; step(); bus.fc_result_valid = 0;
    for (int j = 1; j <= 10; j++) step();
    #1;
    checks++; if ({bus.done, bus.classes, bus.class_idx} !== {1'b1, 10'b0000000001, 4'd0}) begin
      failures++; $display("FAIL all_min got done=%0b cls=%b idx=%0d exp 1 0000000001 0",
                           bus.done, bus.classes, bus.class_idx); end
    step();
  endtask

  task automatic test_reset_mid();
    run_to_conv2();
    for (int i = 0; i < 10; i++) bus.fc_result[i*10 +: 10] = (i == 7) ? 10'd100 : 10'd0;
    bus.fc_result_valid = 1; step(); bus.fc_result_valid = 0;
    step(); step();
    rstn = 1'b0; #1;
    checks++; if (outs() !== 31'd0) begin failures++;
      $display("FAIL reset_mid_async got=%0h exp=0", outs()); end
    step(); #1;
    checks++; if (outs() !== 31'd0) begin failures++;
      $display("FAIL reset_mid_hold got=%0h exp=0", outs()); end
    rstn = 1'b1;
    step();
    run_to_conv2();
    for (int i = 0; i < 10; i++) bus.fc_result[i*10 +: 10] = (i == 9) ? 10'd100 : 10'h3FF;
    bus.fc_result_valid = 1; step(); bus.fc_result_valid = 0;
    for (int j = 1; j <= 10; j++) step();
    #1;
    checks++; if ({bus.done, bus.classes, bus.class_idx} !== {1'b1, 10'b1000000000, 4'd9}) begin
      failures++; $display("FAIL restart_after_reset got done=%0b cls=%b idx=%0d exp 1 1000000000 9",
                           bus.done, bus.classes, bus.class_idx); end
    step();
  endtask

  task automatic test_sum4();
    bus4.conv_result = {4{5'd15}}; bus4.conv_result_valid = 4'hF;
    step();
    checks++; if (bus4.conv2_sum !== 8'd60 || bus4.maxpool_valid !== 1'b0) begin failures++;
      $display("FAIL sum4_idle got sum=%0d mp=%0b exp sum=60 mp=0", bus4.conv2_sum, bus4.maxpool_valid); end
    bus4.conv_result = '0; bus4.conv_result_valid = 4'h0;
    bus4.start = 1; step(); bus4.start = 0;
    bus4.conv_done = 4'hF; step(); bus4.conv_done = 4'h0; step(); #1;
    checks++; if ({bus4.stage, bus4.conv_start} !== 5'b11111) begin failures++;
      $display("FAIL dut4_conv2 got=%0b exp=11111", {bus4.stage, bus4.conv_start}); end
    bus4.conv_result = {4{5'd15}}; bus4.conv_result_valid = 4'hF;
    step();
    checks++; if (bus4.conv2_sum !== 8'd60 || bus4.maxpool_valid !== 1'b1) begin failures++;
      $display("FAIL sum4_conv2 got sum=%0d mp=%0b exp sum=60 mp=1", bus4.conv2_sum, bus4.maxpool_valid); end
    bus4.conv_result = '0; bus4.conv_result_valid = 4'h0;
    step();
    checks++; if (bus4.conv2_sum !== 8'd0 || bus4.maxpool_valid !== 1'b0) begin failures++;
      $display("FAIL sum4_clear got sum=%0d mp=%0b exp sum=0 mp=0", bus4.conv2_sum, bus4.maxpool_valid); end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_conv1();
    test_conv2_replay();
    test_sum2();
    test_argmax_main();
    test_all_min();
    test_reset_mid();
    test_sum4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bnn_seq_ctrl.md
# bnn_seq_ctrl

Parametrised sequencing controller for the binary CNN datapath. It steps the array through CONV1 (pixel stream), CONV2 (binarised feature-map replay), maxpool/FC accumulation and an argmax over the FC scores. The channel count, image size, kernel size and class count are all generic. It sits between the top-level start/done handshake and the per-channel conv units, fc array and output logic, and owns the on-chip binarised fmap storage.

## Interface
- N_CH, 2: number of parallel conv channels (≥1)
- IMG_W, 28: input image side, pixels
- K, 3: conv kernel side
- ACC_W, 5: signed conv result width
- N_CLASS, 10: FC outputs / classes (≥2)
- FC_W, 10: signed FC score width
- clk  in  1  clock, all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  start request, sampled in IDLE only
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, classification valid
- pic_din  in  1  binarised pixel stream during CONV1
- conv_done  in  N_CH  per-channel one-cycle completion pulse
- conv_result  in  N_CH*ACC_W  signed results, channel c at [c*ACC_W +: ACC_W]
- conv_result_valid  in  N_CH  per-channel result strobe
- conv_din  out  N_CH  per-channel serial data into conv units
- conv_start  out  N_CH  per-channel run enable
- weight_en  out  N_CH  per-channel weight-load enable
- stage  out  1  0 = CONV1, 1 otherwise
- conv2_sum  out  ACC_W+$clog2(N_CH)+1  signed registered channel sum
- maxpool_valid  out  1  registered: all channel strobes in CONV2
- fc_result  in  N_CLASS*FC_W  signed scores, class i at [i*FC_W +: FC_W]
- fc_result_valid  in  1  scores valid strobe
- classes  out  N_CLASS  one-hot winning class
- class_idx  out  $clog2(N_CLASS)  winning class index

## Operation
- Parameters: FMAP_N = (IMG_W-K+1)^2 (676 by default); WT_N = N_CH*K*K.
- States: IDLE → CONV1 on start. CONV1 → CONV2 when all done_seen bits are set. CONV2 → ARGMAX on fc_result_valid. ARGMAX → DONE after N_CLASS compare cycles. DONE → IDLE unconditionally.
- done_seen[N_CH] is sticky: bit c is set by conv_done[c] and cleared on entry to CONV1 and on entry to CONV2.
- conv_start[c] = (state ∈ {CONV1, CONV2}) && !done_seen[c].
- Weight counter wt_cnt is cleared on phase entry. It increments while any conv_start is high and saturates at WT_N. weight_en[c] is high when c*K*K ≤ wt_cnt < (c+1)*K*K and conv_start[c] is high.
- Fmap: one FMAP_N-bit array per channel, with per-channel pointer ptr[c].
  - CONV1: on conv_result_valid[c], write fmap[c][ptr[c]] ← ~sign(conv_result[c]), then ptr[c]++.
  - CONV2: ptr[c]++ each cycle conv_start[c] is high.
  - ptr wraps FMAP_N-1 → 0 and is cleared on phase entry.
- conv_din[c] = pic_din in CONV1, else fmap[c][ptr[c]].
- conv2_sum is registered every cycle as the sign-extended sum of all conv_result lanes. It does not overflow at the declared width.
- maxpool_valid is registered and equals (&conv_result_valid) && state==CONV2.
- The fc_result vector is snapshotted into a local register on the fc_result_valid cycle.
- Argmax:
  - best initialises to the most negative FC_W value.
  - Cycle i compares snapshot class i and updates only on strictly greater, so the lowest index wins ties.
  - classes and class_idx update on each win.
- start outside IDLE is ignored.

## Timing
- Reset values: state IDLE, busy 0, done 0, conv_start 0, weight_en 0, conv_din 0, stage 0, conv2_sum 0, maxpool_valid 0, classes 0, class_idx 0, fmap and pointers 0.
- start in cycle t → busy and conv_start high at t+1.
- Last conv_done pulse in cycle t → done_seen full at t+1 → state CONV2 at t+2.
- fc_result_valid at t → ARGMAX during t+1..t+N_CLASS → done high at t+N_CLASS+1 → IDLE at t+N_CLASS+2.
- classes and class_idx hold from done until the next start's ARGMAX rewrites them. They are not cleared on start.
- Simultaneous conv_result_valid and pointer wrap: the write lands at FMAP_N-1 and the pointer goes to 0.
- Reset asserted mid-operation: everything returns asynchronously to the reset values, with no partial done.

## Structure
- Shared package bnn_pkg holds: state encoding (IDLE, CONV1, CONV2, ARGMAX, DONE), the FMAP_N/WT_N derivation functions, and the default ACC_W/FC_W constants.
- Sub-module bnn_argmax (N_CLASS, FC_W) contains the snapshot, sequential compare and one-hot output. It is started by a pulse and returns a finish pulse.

## Test plan
- Defaults, start pulse, both conv_done pulses, fc_result_valid with scores {5,-3,40,40,…,0} → classes=0000000100, class_idx=2, done exactly one cycle, 11 cycles after the valid.
- All scores -512 → class_idx=0, classes=0000000001.
- CONV1 writes 676 results per channel alternating sign; CONV2 replay on conv_din matches the inverted sign bits in order and wraps to index 0 after 675.
- Weight loading: weight_en[0] high for 9 cycles, then weight_en[1] for 9 cycles, then both low, in each phase.
- N_CH=4, conv_results {15,15,15,15} all valid in CONV2 → conv2_sum=60 and maxpool_valid=1 one cycle later.
- Reset asserted in ARGMAX → all outputs 0 immediately; a new start completes normally.
